// File: rtl/reglk_enf_pkg.sv
// -----------------------------------------------------------------------------
// reglk_enf_pkg
// Shared constants, types and helpers for the register-lock enforcer.
//   RLK_RD_BIT / RLK_WR_BIT : lock-byte bit positions for read / write locks
//   LOG_ADDR_BITS           : number of access-address bits kept in a log entry
//   log_entry_t             : {periph, we, addr16} layout of a violation entry
//                             (sized for the default peripheral count)
//   sticky_merge()          : next value of one staged lock byte
// -----------------------------------------------------------------------------
package reglk_enf_pkg;

    localparam int RLK_RD_BIT    = 0;
    localparam int RLK_WR_BIT    = 1;
    localparam int LOG_ADDR_BITS = 16;

    localparam int DEF_NB_PERIPHERALS = 14;
    localparam int DEF_PIDX_W         = $clog2(DEF_NB_PERIPHERALS);

    typedef struct packed {
        logic [DEF_PIDX_W-1:0]    periph;
        logic                     we;
        logic [LOG_ADDR_BITS-1:0] addr16;
    } log_entry_t;

    // Masked bits latch high until reset; unmasked bits simply follow raw.
    function automatic logic [7:0] sticky_merge(input logic [7:0] raw,
                                                input logic [7:0] held,
                                                input logic [7:0] mask);
        return (raw & ~mask) | ((raw | held) & mask);
    endfunction

endpackage

// File: rtl/reglk_enforcer_if.sv
// -----------------------------------------------------------------------------
// reglk_enforcer_if
// Access-check request/verdict and violation-log pop signals of the enforcer.
//   acc_valid_i, acc_periph_i, acc_we_i, acc_addr_i : access check request
//   acc_resp_valid_o, acc_deny_o                    : registered verdict
//   log_valid_o, log_data_o, log_ready_i            : violation FIFO head/pop
// Modports: master = requester / log consumer, slave = enforcer.
// -----------------------------------------------------------------------------
interface reglk_enforcer_if
    import reglk_enf_pkg::*;
#(
    parameter int NB_PERIPHERALS = 14,
    parameter int AXI_ADDR_WIDTH = 64
);
    localparam int PIDX_W = $clog2(NB_PERIPHERALS);
    localparam int LOG_W  = PIDX_W + 1 + LOG_ADDR_BITS;

    logic                      acc_valid_i;
    logic [PIDX_W-1:0]         acc_periph_i;
    logic                      acc_we_i;
    logic [AXI_ADDR_WIDTH-1:0] acc_addr_i;
    logic                      acc_resp_valid_o;
    logic                      acc_deny_o;
    logic                      log_valid_o;
    logic [LOG_W-1:0]          log_data_o;
    logic                      log_ready_i;

    modport master (
        output acc_valid_i, acc_periph_i, acc_we_i, acc_addr_i, log_ready_i,
        input  acc_resp_valid_o, acc_deny_o, log_valid_o, log_data_o
    );

    modport slave (
        input  acc_valid_i, acc_periph_i, acc_we_i, acc_addr_i, log_ready_i,
        output acc_resp_valid_o, acc_deny_o, log_valid_o, log_data_o
    );

endinterface

// File: rtl/reglk_enf_fifo.sv
// -----------------------------------------------------------------------------
// reglk_enf_fifo
// Synchronous FIFO for violation entries; no fall-through, head is driven 0
// when empty. A push while full is accepted only if a pop happens on the
// same edge.
//   clk_i, rst_i : clock, synchronous active-high reset
//   push         : write request, push_data : entry to write
//   pop_ready    : consumer ready; pop happens when head_valid & pop_ready
//   head_valid   : FIFO non-empty, head_data : oldest entry
//   full, empty  : status, occupancy : entries held (0..DEPTH)
// -----------------------------------------------------------------------------
module reglk_enf_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 21
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop_ready,
    output logic                       head_valid,
    output logic [WIDTH-1:0]           head_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign empty      = (count == '0);
    assign full       = (count == OCC_W'(DEPTH));
    assign do_pop     = pop_ready & ~empty;
    assign do_push    = push & (~full | do_pop);
    assign head_valid = ~empty;
    assign head_data  = empty ? '0 : mem[rd_ptr];
    assign occupancy  = count;

    // NOTE: storage has no reset; only pointers and count decide what is valid,
    // so clearing the array would cost flops and buy nothing.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // NOTE: non-blocking assignments for all state so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap by natural overflow.
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + OCC_W'(1);
                2'b01:   count <= count - OCC_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/reglk_enforcer.sv
// -----------------------------------------------------------------------------
// reglk_enforcer
// Stages the per-peripheral lock vector with sticky bits, checks register
// accesses against it, and logs denied accesses in a FIFO with an interrupt.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   reglk_ctrl_i   : raw lock vector, byte p belongs to peripheral p
//   reglk_ctrl_o   : registered, sticky-applied lock vector
//   bus            : access request/verdict and log pop (reglk_enforcer_if.slave)
//   log_ovf_cnt_o  : saturating count of violations dropped on a full log
//   irq_o          : high while the log holds entries
//   viol_cnt_o     : per-peripheral saturating deny counters
// Optional feature macro: REGLK_ENF_STATS_EN (counters present when defined,
// viol_cnt_o tied to 0 otherwise).
// -----------------------------------------------------------------------------
module reglk_enforcer
    import reglk_enf_pkg::*;
#(
    parameter int         NB_PERIPHERALS = 14,
    parameter int         AXI_ADDR_WIDTH = 64,
    parameter int         LOG_DEPTH      = 4,
    parameter logic [7:0] STICKY_MASK    = 8'h03
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [8*NB_PERIPHERALS-1:0] reglk_ctrl_i,
    output logic [8*NB_PERIPHERALS-1:0] reglk_ctrl_o,
    reglk_enforcer_if.slave             bus,
    output logic [15:0]                 log_ovf_cnt_o,
    output logic                        irq_o,
    output logic [8*NB_PERIPHERALS-1:0] viol_cnt_o
);
    localparam int PIDX_W = $clog2(NB_PERIPHERALS);
    localparam int LOG_W  = PIDX_W + 1 + LOG_ADDR_BITS;
    localparam int OCC_W  = $clog2(LOG_DEPTH + 1);

    // ---------------------------------------------------------------- locks
    logic [NB_PERIPHERALS-1:0][7:0] lock_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lock_q <= '0;
        end else begin
            for (int p = 0; p < NB_PERIPHERALS; p++) begin
                lock_q[p] <= sticky_merge(reglk_ctrl_i[8*p +: 8], lock_q[p], STICKY_MASK);
            end
        end
    end

    assign reglk_ctrl_o = lock_q;

    // --------------------------------------------------------- access check
    logic       in_range;
    logic [7:0] sel_lock;
    logic       deny_d;
    logic       push;

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        in_range = (int'(bus.acc_periph_i) < NB_PERIPHERALS);
        sel_lock = '0;
        // Decoded select keeps out-of-range indices from addressing lock_q.
        for (int p = 0; p < NB_PERIPHERALS; p++) begin
            if (int'(bus.acc_periph_i) == p) sel_lock = lock_q[p];
        end
        deny_d = ~in_range |
                 (bus.acc_we_i  & sel_lock[RLK_WR_BIT]) |
                 (~bus.acc_we_i & sel_lock[RLK_RD_BIT]);
        push   = bus.acc_valid_i & deny_d;
    end

    logic resp_valid_q;
    logic deny_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            resp_valid_q <= 1'b0;
            deny_q       <= 1'b0;
        end else begin
            resp_valid_q <= bus.acc_valid_i;
            deny_q       <= push;
        end
    end

    assign bus.acc_resp_valid_o = resp_valid_q;
    assign bus.acc_deny_o       = deny_q;

    // Only the low address bits are logged.
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.acc_addr_i[AXI_ADDR_WIDTH-1:LOG_ADDR_BITS];

    // --------------------------------------------------------- violation log
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_valid;
    logic [OCC_W-1:0] fifo_occ;
    logic [LOG_W-1:0] entry;
    logic             pop;
    logic             push_acc;
    logic             drop;

    assign entry = {bus.acc_periph_i, bus.acc_we_i, bus.acc_addr_i[LOG_ADDR_BITS-1:0]};

    reglk_enf_fifo #(
        .DEPTH (LOG_DEPTH),
        .WIDTH (LOG_W)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .push       (push),
        .push_data  (entry),
        .pop_ready  (bus.log_ready_i),
        .head_valid (fifo_valid),
        .head_data  (bus.log_data_o),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .occupancy  (fifo_occ)
    );

    assign bus.log_valid_o = fifo_valid;
    assign pop             = fifo_valid & bus.log_ready_i;
    assign push_acc        = push & (~fifo_full | pop);
    assign drop            = push & fifo_full & ~pop;

    logic [15:0] ovf_q;
    logic        irq_q;
    logic        irq_d;

    // irq tracks the occupancy the FIFO will hold after this edge, so it
    // rises with log_valid_o and falls right after the last pop.
    assign irq_d = push_acc | (fifo_occ > OCC_W'(1)) |
                   ((fifo_occ == OCC_W'(1)) & ~pop) | (~fifo_empty & ~pop);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ovf_q <= '0;
            irq_q <= 1'b0;
        end else begin
            if (drop && ovf_q != 16'hFFFF) ovf_q <= ovf_q + 16'd1;
            irq_q <= irq_d;
        end
    end

    assign log_ovf_cnt_o = ovf_q;
    assign irq_o         = irq_q;

    // ------------------------------------------------------------ statistics
`ifdef REGLK_ENF_STATS_EN
    logic [NB_PERIPHERALS-1:0][7:0] cnt_q;

    // Counts every in-range deny, including ones the log had to drop.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (push && in_range) begin
            for (int p = 0; p < NB_PERIPHERALS; p++) begin
                if (int'(bus.acc_periph_i) == p && cnt_q[p] != 8'hFF) begin
                    cnt_q[p] <= cnt_q[p] + 8'd1;
                end
            end
        end
    end

    assign viol_cnt_o = cnt_q;
`else
    assign viol_cnt_o = '0;
`endif

endmodule

// File: tb/tb_reglk_enforcer.sv
// -----------------------------------------------------------------------------
// tb_reglk_enforcer
// Self-checking bench: directed scenarios followed by randomized traffic,
// every cycle compared against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_reglk_enforcer;
    import reglk_enf_pkg::*;

    localparam int         NB    = 14;
    localparam int         AW    = 64;
    localparam int         DEPTH = 4;
    localparam logic [7:0] SMASK = 8'h03;
    localparam int         PW    = $clog2(NB);

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b1;
    logic [8*NB-1:0] reglk_ctrl_i;
    logic [8*NB-1:0] reglk_ctrl_o;
    logic [15:0]     log_ovf_cnt_o;
    logic            irq_o;
    logic [8*NB-1:0] viol_cnt_o;

    always #5 clk_i = ~clk_i;

    reglk_enforcer_if #(.NB_PERIPHERALS(NB), .AXI_ADDR_WIDTH(AW)) bus ();

    reglk_enforcer #(
        .NB_PERIPHERALS (NB),
        .AXI_ADDR_WIDTH (AW),
        .LOG_DEPTH      (DEPTH),
        .STICKY_MASK    (SMASK)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .reglk_ctrl_i  (reglk_ctrl_i),
        .reglk_ctrl_o  (reglk_ctrl_o),
        .bus           (bus),
        .log_ovf_cnt_o (log_ovf_cnt_o),
        .irq_o         (irq_o),
        .viol_cnt_o    (viol_cnt_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------ reference model
    logic [7:0] m_lock [NB];
    int         m_cnt  [NB];
    log_entry_t m_q    [$];
    int         m_ovf;
    logic       m_resp;
    logic       m_deny;

    task automatic model_reset();
        for (int p = 0; p < NB; p++) begin
            m_lock[p] = 8'h00;
            m_cnt[p]  = 0;
        end
        m_q.delete();
        m_ovf  = 0;
        m_resp = 1'b0;
        m_deny = 1'b0;
    endtask

    // Applies the rules for one clock edge using the inputs being driven.
    task automatic model_step();
        int         p;
        logic       d;
        log_entry_t e;
        logic [7:0] raw;
        if (rst_i) begin
            model_reset();
            return;
        end
        p = int'(bus.acc_periph_i);
        if (p >= NB)            d = 1'b1;
        else if (bus.acc_we_i)  d = m_lock[p][RLK_WR_BIT];
        else                    d = m_lock[p][RLK_RD_BIT];
        m_resp = bus.acc_valid_i;
        m_deny = bus.acc_valid_i & d;
        if (m_q.size() != 0 && bus.log_ready_i) void'(m_q.pop_front());
        if (m_deny) begin
            e.periph = bus.acc_periph_i;
            e.we     = bus.acc_we_i;
            e.addr16 = bus.acc_addr_i[15:0];
            if (m_q.size() < DEPTH) m_q.push_back(e);
            else if (m_ovf < 65535) m_ovf++;
`ifdef REGLK_ENF_STATS_EN
            if (p < NB && m_cnt[p] < 255) m_cnt[p]++;
`endif
        end
        for (int i = 0; i < NB; i++) begin
            raw = reglk_ctrl_i[8*i +: 8];
            m_lock[i] = (raw & ~SMASK) | ((raw | m_lock[i]) & SMASK);
        end
    endtask

    task automatic check_all();
        logic [8*NB-1:0] exp_lock;
        logic [8*NB-1:0] exp_cnt;
        for (int p = 0; p < NB; p++) begin
            exp_lock[8*p +: 8] = m_lock[p];
            exp_cnt[8*p +: 8]  = 8'(m_cnt[p]);
        end
        check("lock_out",   reglk_ctrl_o, exp_lock);
        check("resp_valid", bus.acc_resp_valid_o, m_resp);
        check("deny",       bus.acc_deny_o, m_deny);
        check("log_valid",  bus.log_valid_o, m_q.size() != 0);
        check("log_data",   bus.log_data_o, (m_q.size() != 0) ? m_q[0] : '0);
        check("ovf_cnt",    log_ovf_cnt_o, 16'(m_ovf));
        check("irq",        irq_o, m_q.size() != 0);
        check("viol_cnt",   viol_cnt_o, exp_cnt);
    endtask

    // Inputs are driven at the falling edge; the DUT samples them at the
    // next rising edge, where the model is stepped, and outputs are checked
    // shortly after.
    task automatic cycle();
        @(posedge clk_i);
        model_step();
        #1;
        check_all();
        @(negedge clk_i);
    endtask

    task automatic idle();
        bus.acc_valid_i  = 1'b0;
        bus.acc_periph_i = '0;
        bus.acc_we_i     = 1'b0;
        bus.acc_addr_i   = '0;
        bus.log_ready_i  = 1'b0;
    endtask

    task automatic req(input int p, input logic we, input logic [15:0] a);
        bus.acc_valid_i  = 1'b1;
        bus.acc_periph_i = PW'(p);
        bus.acc_we_i     = we;
        bus.acc_addr_i   = {48'hDEAD_BEEF_0000, a};
    endtask

    initial begin
        model_reset();
        reglk_ctrl_i = '0;
        idle();
        @(negedge clk_i);

        // Reset state.
        rst_i = 1'b1;
        cycle();
        cycle();
        check("rst_lock", reglk_ctrl_o, '0);
        check("rst_irq",  irq_o, 1'b0);
        rst_i = 1'b0;

        // Sticky write lock on byte 3 and pass-through of bit 2.
        reglk_ctrl_i[31:24] = 8'h02;
        cycle();
        reglk_ctrl_i[31:24] = 8'h04;
        cycle();
        check("sticky_set", reglk_ctrl_o[31:24], 8'h06);
        reglk_ctrl_i[31:24] = 8'h00;
        cycle();
        cycle();
        check("sticky_hold", reglk_ctrl_o[31:24], 8'h02);

        // Write to write-locked periph 3 is denied and logged; read passes.
        req(3, 1'b1, 16'h1234);
        cycle();
        check("wr_deny", bus.acc_deny_o, 1'b1);
        req(3, 1'b0, 16'h5678);
        cycle();
        check("rd_allow",  bus.acc_deny_o, 1'b0);
        check("log_head",  bus.log_data_o, {4'd3, 1'b1, 16'h1234});
        check("irq_set",   irq_o, 1'b1);

        // Out-of-range peripheral always denied.
        req(NB, 1'b0, 16'h00AA);
        cycle();
        check("oor_deny", bus.acc_deny_o, 1'b1);

        // Drain; irq falls right after the last pop.
        idle();
        bus.log_ready_i = 1'b1;
        cycle();
        cycle();
        check("drain_irq", irq_o, 1'b0);

        // Five back-to-back denies into a 4-deep log: one dropped.
        bus.log_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            req(3, 1'b1, 16'(16'h0100 + i));
            cycle();
        end
        check("ovf_one",  log_ovf_cnt_o, 16'd1);
        check("head_old", bus.log_data_o, {4'd3, 1'b1, 16'h0100});

        // Full with simultaneous pop and deny: accepted, no drop.
        bus.log_ready_i = 1'b1;
        req(3, 1'b1, 16'h0F0F);
        cycle();
        check("full_pop_ovf", log_ovf_cnt_o, 16'd1);

        // Drain everything.
        idle();
        bus.log_ready_i = 1'b1;
        for (int i = 0; i < DEPTH; i++) cycle();
        check("drain2_irq", irq_o, 1'b0);

        // Reset mid-stream discards verdicts and log on the same edge.
        bus.log_ready_i = 1'b0;
        req(3, 1'b1, 16'h2222);
        cycle();
        cycle();
        rst_i = 1'b1;
        cycle();
        check("mid_rst_valid", bus.log_valid_o, 1'b0);
        check("mid_rst_resp",  bus.acc_resp_valid_o, 1'b0);
        check("mid_rst_ovf",   log_ovf_cnt_o, 16'd0);
        rst_i = 1'b0;
        idle();

        // 300 read denies to periph 0 saturate its counter.
        reglk_ctrl_i[7:0] = 8'h03;
        cycle();
        reglk_ctrl_i[7:0] = 8'h00;
        bus.log_ready_i = 1'b1;
        for (int i = 0; i < 300; i++) begin
            req(0, 1'b0, 16'(i));
            cycle();
        end
        req(NB + 1, 1'b1, 16'h0001);
        cycle();
`ifdef REGLK_ENF_STATS_EN
        check("stats_sat", viol_cnt_o[7:0], 8'hFF);
`else
        check("stats_off", viol_cnt_o, '0);
`endif

        // Randomized traffic.
        rst_i = 1'b1;
        idle();
        cycle();
        rst_i = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            rst_i = ($urandom_range(0, 199) == 0);
            for (int p = 0; p < NB; p++) begin
                reglk_ctrl_i[8*p +: 8] = (8'($urandom_range(0, 255)) & ~SMASK) |
                                         (($urandom_range(0, 39) == 0) ? 8'($urandom_range(0, 3)) : 8'h00);
            end
            bus.acc_valid_i  = ($urandom_range(0, 3) != 0);
            bus.acc_periph_i = PW'($urandom_range(0, 15));
            bus.acc_we_i     = 1'($urandom_range(0, 1));
            bus.acc_addr_i   = {$urandom(), $urandom()};
            bus.log_ready_i  = ($urandom_range(0, 2) == 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/reglk_enforcer.md
Name: reglk_enforcer

Overview:
- Sits directly downstream of the register-lock block; consumes its flattened per-peripheral lock vector (8 bits per peripheral).
- Registers the lock vector with sticky semantics and distributes it to the peripherals.
- Checks every peripheral register access against the current lock bits and returns a registered allow/deny verdict.
- Logs denied accesses in a small FIFO that software drains; raises an interrupt while the FIFO holds entries.

Parameters:
- NB_PERIPHERALS, 14, number of peripherals; each owns one 8-bit lock byte.
- AXI_ADDR_WIDTH, 64, width of the observed access address.
- LOG_DEPTH, 4, violation FIFO depth; power of two, minimum 2.
- STICKY_MASK, 8'h03, lock-byte bits that stay set once set, until reset.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- reglk_ctrl_i  in  8*NB_PERIPHERALS  raw lock vector from the lock register block; byte p belongs to peripheral p.
- reglk_ctrl_o  out  8*NB_PERIPHERALS  registered, sticky-applied lock vector sent to the peripherals.
- acc_valid_i  in  1  access check request.
- acc_periph_i  in  $clog2(NB_PERIPHERALS)  target peripheral index.
- acc_we_i  in  1  1 = write, 0 = read.
- acc_addr_i  in  AXI_ADDR_WIDTH  access address.
- acc_resp_valid_o  out  1  verdict valid.
- acc_deny_o  out  1  1 = access denied.
- log_valid_o  out  1  FIFO head valid.
- log_data_o  out  $clog2(NB_PERIPHERALS)+17  head entry: {periph, we, addr[15:0]}.
- log_ready_i  in  1  pop the head.
- log_ovf_cnt_o  out  16  count of dropped violations; saturates.
- irq_o  out  1  high while the FIFO is non-empty.
- viol_cnt_o  out  8*NB_PERIPHERALS  per-peripheral violation counts (optional feature only).

Behaviour:
- Reset:
  - reglk_ctrl_o = 0, acc_resp_valid_o = 0, acc_deny_o = 0.
  - FIFO empty: log_valid_o = 0, irq_o = 0.
  - log_ovf_cnt_o = 0, viol_cnt_o = 0.
  - Reset asserted mid-operation discards all in-flight verdicts and FIFO contents on the same edge.
- Lock staging, 1-cycle latency, per byte p:
  - lock_q[p] <= (reglk_ctrl_i[p] & ~STICKY_MASK) | ((reglk_ctrl_i[p] | lock_q[p]) & STICKY_MASK).
  - Sticky bits ignore a later 1->0 on the input.
  - reglk_ctrl_o = lock_q.
- Lock-byte bit meaning: bit0 = read lock, bit1 = write lock. Bits 2..7 pass through unchecked.
- Access check, 1-cycle latency:
  - acc_resp_valid_o follows acc_valid_i delayed by one cycle.
  - Deny if acc_periph_i >= NB_PERIPHERALS, or (acc_we_i & lock_q[p][1]), or (~acc_we_i & lock_q[p][0]).
  - The check uses lock_q as registered before the request edge, so a lock change takes effect for requests issued the cycle after it appears on reglk_ctrl_o.
  - One request per cycle, back-to-back allowed, no stall.
  - acc_deny_o = 0 whenever acc_resp_valid_o = 0.
- Violation push:
  - Occurs on the same edge that registers a deny verdict.
  - Entry = {acc_periph_i, acc_we_i, acc_addr_i[15:0]}.
- FIFO:
  - Pop happens on log_valid_o & log_ready_i.
  - Full, no pop: new entry dropped, log_ovf_cnt_o += 1, saturating at 16'hFFFF.
  - Full with simultaneous pop: push accepted, no drop.
  - Empty with simultaneous push: entry visible the next cycle; no fall-through.
  - Pointers wrap modulo LOG_DEPTH; occupancy counter is 0..LOG_DEPTH.
  - log_data_o is undefined (driven 0) when empty.
- irq_o is registered: irq_o = (occupancy != 0).

Optional Feature:
- Macro REGLK_ENF_STATS_EN.
- Defined: per-peripheral 8-bit saturating counters (stop at 8'hFF) increment on each deny to an in-range peripheral, whether or not the log dropped the entry. Out-of-range denies are not counted.
- Undefined: viol_cnt_o is tied to 0 and no counter flops exist.

Decomposition:
- Package reglk_enf_pkg:
  - Lock-bit index constants RLK_RD_BIT = 0, RLK_WR_BIT = 1.
  - Packed struct log_entry_t {periph, we, addr16}.
  - Constant LOG_ADDR_BITS = 16.
- Sub-module reglk_enf_fifo: synchronous FIFO with valid/ready pop, push, full/empty, and occupancy outputs.

Test Plan:
- Sticky write lock: reglk_ctrl_i byte3 = 8'h02 for one cycle, then 8'h00 -> reglk_ctrl_o byte3 = 8'h02 from the next cycle until rst_i. Bit 2 set then cleared follows the input with 1-cycle delay.
- Write to a write-locked periph 3, addr 0x1234 -> acc_deny_o = 1 one cycle later. log_data_o = {3, 1, 16'h1234}, log_valid_o and irq_o high. A read to the same periph -> deny = 0.
- acc_periph_i = NB_PERIPHERALS -> deny = 1, logged. With the optional feature defined, no counter changes.
- Five back-to-back denies with LOG_DEPTH = 4 and log_ready_i = 0 -> 4 entries held, log_ovf_cnt_o = 1.
  - Full plus a simultaneous pop and deny -> occupancy stays 4, ovf unchanged.
- Drain all entries -> irq_o falls the cycle after the last pop.
  - rst_i asserted mid-stream -> all outputs 0 on the next edge.
- REGLK_ENF_STATS_EN defined: 300 denies to periph 0 -> viol_cnt_o byte0 = 8'hFF. Without the macro -> viol_cnt_o = 0.
